jk_universal_register: RTL and testbench
========================================

// Module: jk_universal_register
// PURPOSE
//   Parametrised WIDTH-bit register built on JK flip-flop semantics; successor to the single-bit JK flip-flop.
//   Adds per-bit JK update, parallel load, serial shift in both directions, up/down counting and sync clear.
//   Used as the general-purpose state/counter element in the flip-flop practice designs.
//   Single clock domain; all state changes occur on the rising edge of clk.
// PARAMETERS
//   WIDTH      8      number of JK bit cells; legal range 2..32
//   RESET_VAL  0      value loaded into q on async reset; WIDTH bits
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      update enable; 0 = hold regardless of mode
//   mode     in   3      operation select (see BEHAVIOUR)
//   j        in   WIDTH  per-bit J inputs (mode JK only)
//   k        in   WIDTH  per-bit K inputs (mode JK only)
//   d        in   WIDTH  parallel load data (mode LOAD only)
//   ser_in   in   1      serial input for SHL/SHR
//   q        out  WIDTH  registered state
//   q_n      out  WIDTH  bitwise complement of q, always ~q
//   ser_out  out  1      SHL: q[WIDTH-1]; SHR: q[0]; other modes: 0 (combinational)
//   tc       out  1      terminal count (combinational, see below)
// BEHAVIOUR
//   - Reset: rst_n low -> q = RESET_VAL immediately, independent of clk; q_n = ~RESET_VAL.
//     Reset mid-operation aborts the pending update; first update after release is on the first clk edge with rst_n high.
//   - Latency: one cycle; inputs sampled at rising edge, q valid after that edge. No internal pipeline.
//   - en = 0: q holds, every mode.
//   - mode when en = 1:
//     000 HOLD   q unchanged
//     001 JK     per bit i: {j,k}=00 hold, 01 q[i]=0, 10 q[i]=1, 11 q[i]=~q[i]
//     010 LOAD   q = d
//     011 SHL    q = {q[WIDTH-2:0], ser_in}
//     100 SHR    q = {ser_in, q[WIDTH-1:1]}
//     101 UP     q = q + 1, modulo 2^WIDTH (all-ones wraps to 0)
//     110 DOWN   q = q - 1, modulo 2^WIDTH (0 wraps to all-ones)
//     111 CLEAR  q = 0 (synchronous; not RESET_VAL)
//   - Arithmetic is unsigned WIDTH bits; carry/borrow out is discarded except through tc.
//   - tc = en & ((mode==UP & q==all-ones) | (mode==DOWN & q==0)); it flags the cycle before wrap.
//   - Mode may change every cycle; no state is carried between modes except q itself.
//   - Inputs j, k, d, ser_in are don't-care in modes that do not use them.
// CONFIGURATION
//   JK_PARITY_EN defined:
//     extra output port  parity  out  1  registered even parity (^q) of the value q takes after the edge.
//     parity resets to ^RESET_VAL; updates in the same edge as q, never lags q.
//   JK_PARITY_EN undefined: port parity absent; no parity logic.
// TESTING (WIDTH=8, RESET_VAL=8'hA5)
//   1 rst_n low at t=3 (between edges) -> q=8'hA5, q_n=8'h5A before next edge; release, mode HOLD -> q stays 8'hA5.
//   2 LOAD d=8'h0F, then JK j=8'hF0 k=8'h3C -> q=8'h0F then q=8'hF3 (bits 7:6 set, 5:4 toggle, 3:2 clear, 1:0 hold).
//   3 LOAD 8'hFE, UP x2 -> q=8'hFF with tc=1, then q=8'h00 with tc=0; DOWN from 8'h00 -> tc=1, q=8'hFF.
//   4 LOAD 8'h81, SHL ser_in=0 -> ser_out=1 before edge, q=8'h02; SHR ser_in=1 -> q=8'h81.
//   5 en=0 with mode UP for 3 edges -> q unchanged, tc=0; CLEAR with en=1 -> q=8'h00 (not 8'hA5).
//   6 UP running from 8'h10, assert rst_n low mid-cycle -> q=8'hA5 at once; parity (if JK_PARITY_EN) = 0.

Source files
------------

// File: rtl/jk_universal_register.sv
// WIDTH-bit register with JK, load, shift, count and clear modes.
// Optional registered even-parity output when JK_PARITY_EN is defined.
module jk_universal_register #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             ser_out,
`ifdef JK_PARITY_EN
  output logic             tc,
  output logic             parity
`else
  output logic             tc
`endif
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_JK    = 3'b001;
  localparam logic [2:0] MODE_LOAD  = 3'b010;
  localparam logic [2:0] MODE_SHL   = 3'b011;
  localparam logic [2:0] MODE_SHR   = 3'b100;
  localparam logic [2:0] MODE_UP    = 3'b101;
  localparam logic [2:0] MODE_DOWN  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_next;

  // Next-state selection; en low holds in every mode.
  always_comb begin
    q_next = q;
    if (en) begin
      unique case (mode)
        MODE_HOLD:  q_next = q;
        MODE_JK:    q_next = (j & ~q) | (~k & q);
        MODE_LOAD:  q_next = d;
        MODE_SHL:   q_next = {q[WIDTH-2:0], ser_in};
        MODE_SHR:   q_next = {ser_in, q[WIDTH-1:1]};
        MODE_UP:    q_next = q + ONE;
        MODE_DOWN:  q_next = q - ONE;
        MODE_CLEAR: q_next = '0;
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

`ifdef JK_PARITY_EN
  // Parity is computed from q_next so it lands on the same edge as q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= ^RESET_VAL;
    end else begin
      parity <= ^q_next;
    end
  end
`endif

  assign q_n = ~q;

  // Serial tap follows shift direction; zero outside shift modes.
  always_comb begin
    ser_out = 1'b0;
    if (mode == MODE_SHL) begin
      ser_out = q[WIDTH-1];
    end else if (mode == MODE_SHR) begin
      ser_out = q[0];
    end
  end

  assign tc = en & (((mode == MODE_UP) & (q == ALL_ONES)) |
                    ((mode == MODE_DOWN) & (q == '0)));

endmodule

// File: tb/tb_jk_universal_register.sv
// Directed-vector bench for jk_universal_register (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_universal_register;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_JK    = 3'b001;
  localparam logic [2:0] M_LOAD  = 3'b010;
  localparam logic [2:0] M_SHL   = 3'b011;
  localparam logic [2:0] M_SHR   = 3'b100;
  localparam logic [2:0] M_UP    = 3'b101;
  localparam logic [2:0] M_DOWN  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             ser_out;
  logic             tc;
`ifdef JK_PARITY_EN
  logic             parity;
`endif

  int nvec;
  int nfail;

  jk_universal_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .d       (d),
    .ser_in  (ser_in),
    .q       (q),
    .q_n     (q_n),
    .ser_out (ser_out),
`ifdef JK_PARITY_EN
    .tc      (tc),
    .parity  (parity)
`else
    .tc      (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if (q !== 8'hA5) begin
      nfail++; $display("FAIL reset_q: got %h want a5", q);
    end
    nvec++;
    if (q_n !== 8'h5A) begin
      nfail++; $display("FAIL reset_q_n: got %h want 5a", q_n);
    end
`ifdef JK_PARITY_EN
    nvec++;
    if (parity !== 1'b0) begin
      nfail++; $display("FAIL reset_parity: got %b want 0", parity);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = M_HOLD;
    tick();
    nvec++;
    if (q !== 8'hA5) begin
      nfail++; $display("FAIL hold_after_reset: got %h want a5", q);
    end
    tick();
    nvec++;
    if (q !== 8'hA5) begin
      nfail++; $display("FAIL hold_second_edge: got %h want a5", q);
    end
  endtask

  task automatic test_jk();
    mode = M_LOAD; d = 8'h0F;
    tick();
    nvec++;
    if (q !== 8'h0F) begin
      nfail++; $display("FAIL load_0f: got %h want 0f", q);
    end
    mode = M_JK; j = 8'hF0; k = 8'h3C; d = 8'h77;
    tick();
    nvec++;
    if (q !== 8'hF3) begin
      nfail++; $display("FAIL jk_mixed: got %h want f3", q);
    end
    nvec++;
    if (q_n !== 8'h0C) begin
      nfail++; $display("FAIL jk_mixed_q_n: got %h want 0c", q_n);
    end
    j = 8'hFF; k = 8'hFF;
    tick();
    nvec++;
    if (q !== 8'h0C) begin
      nfail++; $display("FAIL jk_toggle_all: got %h want 0c", q);
    end
  endtask

  task automatic test_count();
    mode = M_LOAD; d = 8'hFE;
    tick();
    nvec++;
    if (q !== 8'hFE) begin
      nfail++; $display("FAIL load_fe: got %h want fe", q);
    end
`ifdef JK_PARITY_EN
    nvec++;
    if (parity !== 1'b1) begin
      nfail++; $display("FAIL parity_fe: got %b want 1", parity);
    end
`endif
    mode = M_UP;
    #1;
    nvec++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL tc_up_fe: got %b want 0", tc);
    end
    tick();
    nvec++;
    if (q !== 8'hFF || tc !== 1'b1) begin
      nfail++; $display("FAIL up_to_ff: got q=%h tc=%b want q=ff tc=1", q, tc);
    end
    tick();
    nvec++;
    if (q !== 8'h00 || tc !== 1'b0) begin
      nfail++; $display("FAIL up_wrap: got q=%h tc=%b want q=00 tc=0", q, tc);
    end
    mode = M_DOWN;
    #1;
    nvec++;
    if (tc !== 1'b1) begin
      nfail++; $display("FAIL tc_down_00: got %b want 1", tc);
    end
    tick();
    nvec++;
    if (q !== 8'hFF || tc !== 1'b0) begin
      nfail++; $display("FAIL down_wrap: got q=%h tc=%b want q=ff tc=0", q, tc);
    end
    tick();
    nvec++;
    if (q !== 8'hFE) begin
      nfail++; $display("FAIL down_fe: got %h want fe", q);
    end
  endtask

  task automatic test_shift();
    mode = M_LOAD; d = 8'h81;
    tick();
    mode = M_SHL; ser_in = 1'b0;
    #1;
    nvec++;
    if (ser_out !== 1'b1) begin
      nfail++; $display("FAIL ser_out_shl: got %b want 1", ser_out);
    end
    tick();
    nvec++;
    if (q !== 8'h02) begin
      nfail++; $display("FAIL shl_81: got %h want 02", q);
    end
    mode = M_SHR; ser_in = 1'b1;
    #1;
    nvec++;
    if (ser_out !== 1'b0) begin
      nfail++; $display("FAIL ser_out_shr: got %b want 0", ser_out);
    end
    tick();
    nvec++;
    if (q !== 8'h81) begin
      nfail++; $display("FAIL shr_02: got %h want 81", q);
    end
    mode = M_SHR;
    #1;
    nvec++;
    if (ser_out !== 1'b1) begin
      nfail++; $display("FAIL ser_out_shr_81: got %b want 1", ser_out);
    end
    mode = M_HOLD;
    #1;
    nvec++;
    if (ser_out !== 1'b0) begin
      nfail++; $display("FAIL ser_out_hold: got %b want 0", ser_out);
    end
    mode = M_SHL; ser_in = 1'b1;
    tick();
    nvec++;
    if (q !== 8'h03) begin
      nfail++; $display("FAIL shl_in1: got %h want 03", q);
    end
  endtask

  task automatic test_enable();
    mode = M_LOAD; d = 8'hFF;
    tick();
    en = 1'b0; mode = M_UP;
    #1;
    nvec++;
    if (tc !== 1'b0) begin
      nfail++; $display("FAIL tc_en0: got %b want 0", tc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (q !== 8'hFF || tc !== 1'b0) begin
        nfail++; $display("FAIL en0_hold_%0d: got q=%h tc=%b want q=ff tc=0", i, q, tc);
      end
    end
    en = 1'b0; mode = M_LOAD; d = 8'h12;
    tick();
    nvec++;
    if (q !== 8'hFF) begin
      nfail++; $display("FAIL en0_load: got %h want ff", q);
    end
    en = 1'b1; mode = M_CLEAR;
    tick();
    nvec++;
    if (q !== 8'h00) begin
      nfail++; $display("FAIL clear: got %h want 00", q);
    end
  endtask

  task automatic test_midreset();
    mode = M_LOAD; d = 8'h10;
    tick();
    mode = M_UP;
    tick();
    nvec++;
    if (q !== 8'h11) begin
      nfail++; $display("FAIL up_10: got %h want 11", q);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (q !== 8'hA5 || q_n !== 8'h5A) begin
      nfail++; $display("FAIL midreset: got q=%h q_n=%h want q=a5 q_n=5a", q, q_n);
    end
`ifdef JK_PARITY_EN
    nvec++;
    if (parity !== 1'b0) begin
      nfail++; $display("FAIL midreset_parity: got %b want 0", parity);
    end
`endif
    tick();
    nvec++;
    if (q !== 8'hA5) begin
      nfail++; $display("FAIL reset_held_edge: got %h want a5", q);
    end
    rst_n = 1'b1;
    tick();
    nvec++;
    if (q !== 8'hA6) begin
      nfail++; $display("FAIL up_after_release: got %h want a6", q);
    end
`ifdef JK_PARITY_EN
    nvec++;
    if (parity !== 1'b0) begin
      nfail++; $display("FAIL parity_a6: got %b want 0", parity);
    end
`endif
  endtask

  initial begin
    nvec   = 0;
    nfail  = 0;
    rst_n  = 1'b1;
    en     = 1'b0;
    mode   = M_HOLD;
    j      = '0;
    k      = '0;
    d      = '0;
    ser_in = 1'b0;
    test_reset();
    test_jk();
    test_count();
    test_shift();
    test_enable();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
